// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (shift, subtract, restore)
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {r, q_msb};
  assign diff    = {1'b0, shifted} - {2'b00, d};

  // Since r < d, a non-borrowing difference is < d and so diff[WIDTH] is
  // zero; folding it into the borrow keeps every difference bit meaningful.
  assign q_bit  = ~(diff[WIDTH+1] | diff[WIDTH]);
  assign r_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with valid/ready handshake
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d     = divisor;
          dbz_d   = (divisor == '0);
          state_d = BUSY;
          if (divisor == '0) begin
            // Zero divisor spends one frozen BUSY cycle holding the RISC-V result
            q_d   = '1;
            r_d   = dividend;
            cnt_d = CW'(1);
          end else begin
            q_d   = dividend;
            r_d   = '0;
            cnt_d = CW'(WIDTH);
          end
        end
      end
      BUSY: begin
        if (!dbz_q) begin
          r_d = step_r;
          q_d = {q_q[WIDTH-2:0], step_q};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule
